tinyqv_prefetch_queue: RTL and testbench
========================================

Name: tinyqv_prefetch_queue

Overview:
- Parametrised instruction prefetch queue for TinyQV. It replaces the fixed 4-halfword fetch buffer inside the CPU.
- Accepts 16-bit halfwords from the QSPI instruction fetch interface into a circular buffer of 2^DEPTH_LOG2 halfwords.
- Presents the next 16- or 32-bit instruction, aligned on any halfword, to the decoder.
- Adds over the previous generation: configurable depth, explicit occupancy, fetch-window throttling, and a single-cycle redirect/flush port for branches, returns and interrupts.

Parameters:
- DEPTH_LOG2, 2: log2 of buffer depth in halfwords; legal range 1..4.
- ADDR_HI, 23: top bit of halfword address; addresses are [ADDR_HI:1].
- STALL_MARGIN, 0: extra free halfwords kept in reserve before fetch_stall asserts; must be less than 2^DEPTH_LOG2 - 1.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- fetch_addr  out  ADDR_HI  halfword address of the next halfword to fetch: pc + count
- fetch_restart  out  1  request that the fetcher (re)start at fetch_addr
- fetch_stall  out  1  fetcher must pause: buffer is (nearly) full
- fetch_started  in  1  fetcher has begun streaming
- fetch_stopped  in  1  fetcher has stopped streaming
- fetch_data  in  16  incoming halfword
- fetch_ready  in  1  fetch_data valid this cycle
- instr  out  32  {buf[rd+1], buf[rd]}
- instr_ready  out  1  a complete instruction is at the head
- instr_len  out  2  01 = compressed (16-bit), 10 = 32-bit; decoded from instr[1:0]
- pc  out  ADDR_HI  halfword address of the head instruction
- count  out  DEPTH_LOG2+1  halfwords held
- consume  in  1  pop the head instruction (instr_len halfwords)
- redirect  in  1  flush the queue and jump
- redirect_addr  in  ADDR_HI  new pc

Behaviour:
- Reset values: rd_ptr = wr_ptr = 0, pc = 0, running = 0, count = 0, fetch_restart = 1, fetch_stall = 0, instr_ready = 0, fetch_addr = 0. Buffer RAM is not reset.
- Pointers: rd_ptr and wr_ptr are DEPTH_LOG2+1 bits wide; count = wr_ptr - rd_ptr, modulo 2^(DEPTH_LOG2+1).
- Buffer states: full when count == 2^DEPTH_LOG2; empty when count == 0.
- Fetch state machine, 2 states:
  - IDLE -> RUN on fetch_started.
  - RUN -> IDLE on fetch_stopped or redirect.
  - Redirect forces IDLE regardless of fetch_started.
- Write: when fetch_ready && running && !redirect, write buf[wr_ptr] and increment wr_ptr. fetch_ready in IDLE is discarded.
- Overrun: a write while full is dropped, and a sim-only assertion fires.
- instr_ready = count >= 2, or count == 1 with instr[1:0] != 11.
- instr upper half is don't-care when count < 2.
- Consume:
  - Legal only when instr_ready. rd_ptr and pc advance by instr_len in the same cycle.
  - pc wraps modulo 2^ADDR_HI.
  - Consume while !instr_ready is ignored and flagged by assertion.
- Simultaneous write and consume in one cycle: both take effect; count changes by +1 - instr_len.
- fetch_stall is combinational from the next-state count: it asserts when next_count >= 2^DEPTH_LOG2 - STALL_MARGIN - (running ? 1 : 0). This lets the fetcher see the stall one halfword early.
- Redirect has the highest priority, and takes one cycle:
  - pc <= redirect_addr; rd_ptr <= wr_ptr <= 0; running <= 0.
  - Any same-cycle write or consume is discarded.
  - The next cycle has count = 0 and fetch_addr = redirect_addr.
- fetch_restart = !running && !redirect. It is guaranteed low for at least the redirect cycle, so the fetcher sees a restart edge.
- Wrap-around: buffer indices use ptr[DEPTH_LOG2-1:0]. A 32-bit instruction straddling the last/first slot is read correctly.
- Latency:
  - A halfword written at cycle N is visible in instr/instr_ready at cycle N+1.
  - Redirect to the first instr_ready takes at least 2 cycles plus fetcher latency.
- Reset asserted mid-operation returns all state to the reset values immediately, asynchronously. Deassertion is synchronised externally.

Decomposition:
- Shared package tinyqv_fetch_pkg holds:
  - INSTR_LEN_16 = 2'b01 and INSTR_LEN_32 = 2'b10.
  - function is_compressed(instr[1:0]).
  - function halfword pointer width from DEPTH_LOG2.
- One natural sub-module: tinyqv_prefetch_ram, a 16-bit x 2^DEPTH_LOG2 register array with 1 write port and 2 read ports (rd, rd+1).
- Pointer logic, the fetch state machine and the stall logic stay in the top.

Test Plan:
- Reset, then fetch_started and 4 halfwords 0x0001,0x1111,0x2222,0x3333 at DEPTH_LOG2=2 -> fetch_stall high at the 3rd write; count=4; instr=0x11110001; instr_ready=1; instr_len=01.
- Fill the queue with a 32-bit instruction 0x00A00093 beginning at slot 3 (straddling the wrap) -> instr=0x00A00093; instr_len=10; consume -> count drops by 2; pc +2.
- Simultaneous fetch_ready and consume of a 16-bit instruction with count=2 -> count stays 2; pc +1 halfword.
- Redirect to 0x000100 while fetch_ready high and count=3 -> next cycle count=0, pc=0x000100, fetch_addr=0x000100; fetch_restart low in the redirect cycle and high after it; the data halfword is discarded.
- Head halfword 0x0093 (32-bit low half) with count=1 -> instr_ready=0; after the next halfword arrives -> instr_ready=1.
- Assert rstn low during RUN with count=3 -> count=0, fetch_restart=1, fetch_stall=0, pc=0 without waiting for a clock edge.

Source files
------------

// File: rtl/tinyqv_fetch_pkg.sv
// Shared definitions for the TinyQV instruction prefetch path.
package tinyqv_fetch_pkg;

    localparam logic [1:0] INSTR_LEN_16 = 2'b01;
    localparam logic [1:0] INSTR_LEN_32 = 2'b10;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    function automatic logic is_compressed(input logic [1:0] opcode_lo);
        return opcode_lo != 2'b11;
    endfunction

    // One extra bit beyond the index distinguishes full from empty.
    function automatic int ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/tinyqv_prefetch_ram.sv
// Halfword storage for the prefetch queue: one write port, two read ports (head and head+1).
module tinyqv_prefetch_ram #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [15:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr0,
    input  logic [DEPTH_LOG2-1:0] raddr1,
    output logic [15:0]           rdata0,
    output logic [15:0]           rdata1
);

    logic [15:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/tinyqv_prefetch_queue.sv
// Circular halfword prefetch queue feeding the TinyQV decoder, with redirect/flush.
//   state      | meaning
//   FETCH_IDLE | fetcher not streaming; fetch_restart asserted, incoming data dropped
//   FETCH_RUN  | fetcher streaming; valid halfwords are written into the queue
module tinyqv_prefetch_queue
    import tinyqv_fetch_pkg::*;
#(
    parameter int DEPTH_LOG2   = 2,
    parameter int ADDR_HI      = 23,
    parameter int STALL_MARGIN = 0
) (
    input  logic               clk,
    input  logic               rstn,
    output logic [ADDR_HI:1]   fetch_addr,
    output logic               fetch_restart,
    output logic               fetch_stall,
    input  logic               fetch_started,
    input  logic               fetch_stopped,
    input  logic [15:0]        fetch_data,
    input  logic               fetch_ready,
    output logic [31:0]        instr,
    output logic               instr_ready,
    output logic [1:0]         instr_len,
    output logic [ADDR_HI:1]   pc,
    output logic [DEPTH_LOG2:0] count,
    input  logic               consume,
    input  logic               redirect,
    input  logic [ADDR_HI:1]   redirect_addr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = ptr_width(DEPTH_LOG2);
    localparam logic [PW-1:0] FULL_CNT   = PW'(DEPTH);
    localparam logic [PW-1:0] STALL_IDLE = PW'(DEPTH - STALL_MARGIN);
    localparam logic [PW-1:0] STALL_RUN  = PW'(DEPTH - STALL_MARGIN - 1);

    fetch_state_e state, state_nxt;
    logic [PW-1:0]         rd_ptr, wr_ptr, count_w, next_count, len_w;
    logic [ADDR_HI:1]      pc_q;
    logic [DEPTH_LOG2-1:0] rd_idx, rd_idx1;
    logic [15:0]           head_lo, head_hi;
    logic                  running, full, compressed, do_write, do_consume;

    tinyqv_prefetch_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk    (clk),
        .we     (do_write),
        .waddr  (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata  (fetch_data),
        .raddr0 (rd_idx),
        .raddr1 (rd_idx1),
        .rdata0 (head_lo),
        .rdata1 (head_hi)
    );

    assign rd_idx     = rd_ptr[DEPTH_LOG2-1:0];
    assign rd_idx1    = rd_idx + 1'b1;
    assign instr      = {head_hi, head_lo};
    assign count_w    = wr_ptr - rd_ptr;
    assign full       = count_w == FULL_CNT;
    assign running    = state == FETCH_RUN;
    assign compressed = is_compressed(head_lo[1:0]);
    assign instr_len  = compressed ? INSTR_LEN_16 : INSTR_LEN_32;
    assign len_w      = PW'(instr_len);
    assign instr_ready = (count_w >= PW'(2)) || (count_w == PW'(1) && compressed);

    assign do_write   = fetch_ready && running && !redirect && !full;
    assign do_consume = consume && instr_ready && !redirect;

    assign next_count = redirect ? '0
                      : count_w + PW'(do_write) - (do_consume ? len_w : '0);
    assign fetch_stall   = next_count >= (running ? STALL_RUN : STALL_IDLE);
    assign fetch_restart = !running && !redirect;
    assign fetch_addr    = pc_q + ADDR_HI'(count_w);
    assign pc            = pc_q;
    assign count         = count_w;

    always_comb begin
        state_nxt = state;
        if (redirect)                              state_nxt = FETCH_IDLE;
        else if (state == FETCH_IDLE && fetch_started) state_nxt = FETCH_RUN;
        else if (state == FETCH_RUN && fetch_stopped)  state_nxt = FETCH_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= FETCH_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc_q   <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc_q   <= redirect_addr;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_consume) begin
                rd_ptr <= rd_ptr + len_w;
                pc_q   <= pc_q + ADDR_HI'(instr_len);
            end
        end
    end

    // A write arriving while full is dropped; a pop with no complete instruction is ignored.
    a_no_overrun: assert property (@(posedge clk) disable iff (!rstn)
        (fetch_ready && running && !redirect) |-> !full);
    a_legal_consume: assert property (@(posedge clk) disable iff (!rstn)
        (consume && !redirect) |-> instr_ready);

endmodule

// File: tb/tb_tinyqv_prefetch_queue.sv
// Directed bench for tinyqv_prefetch_queue at default parameters (4 halfwords, 23-bit pc).
module tb_tinyqv_prefetch_queue;

    logic        clk, rstn;
    logic [23:1] fetch_addr, pc, redirect_addr;
    logic        fetch_restart, fetch_stall, fetch_started, fetch_stopped;
    logic [15:0] fetch_data;
    logic        fetch_ready, instr_ready, consume, redirect;
    logic [31:0] instr;
    logic [1:0]  instr_len;
    logic [2:0]  count;

    int n_chk = 0;
    int n_bad = 0;

    tinyqv_prefetch_queue dut (
        .clk           (clk),
        .rstn          (rstn),
        .fetch_addr    (fetch_addr),
        .fetch_restart (fetch_restart),
        .fetch_stall   (fetch_stall),
        .fetch_started (fetch_started),
        .fetch_stopped (fetch_stopped),
        .fetch_data    (fetch_data),
        .fetch_ready   (fetch_ready),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .instr_len     (instr_len),
        .pc            (pc),
        .count         (count),
        .consume       (consume),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic exp_stall);
        fetch_ready = 1'b1;
        fetch_data  = d;
        #1;
        chk("push_stall", fetch_stall, exp_stall);
        tick();
        fetch_ready = 1'b0;
        #1;
    endtask

    task automatic pop();
        consume = 1'b1;
        #1;
        tick();
        consume = 1'b0;
        #1;
    endtask

    task automatic start_fetch();
        fetch_started = 1'b1;
        tick();
        fetch_started = 1'b0;
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        fetch_started = 0; fetch_stopped = 0; fetch_ready = 0;
        fetch_data = '0; consume = 0; redirect = 0; redirect_addr = '0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_restart", fetch_restart, 1);
        chk("rst_stall", fetch_stall, 0);
        chk("rst_ready", instr_ready, 0);
        chk("rst_faddr", fetch_addr, 0);
        chk("rst_pc", pc, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // fill to full; stall shows on the 3rd write
        start_fetch();
        chk("run_restart", fetch_restart, 0);
        push(16'h0001, 0);
        push(16'h1111, 0);
        push(16'h2222, 1);
        push(16'h3333, 1);
        chk("full_count", count, 4);
        chk("full_instr", instr, 32'h1111_0001);
        chk("full_ready", instr_ready, 1);
        chk("full_len", instr_len, 2'b01);
        chk("full_faddr", fetch_addr, 4);

        pop();
        chk("pop1_count", count, 3);
        chk("pop1_pc", pc, 1);
        chk("pop1_instr", instr, 32'h2222_1111);

        // redirect with a same-cycle halfword that must be dropped
        redirect = 1'b1; redirect_addr = 23'h000100;
        fetch_ready = 1'b1; fetch_data = 16'hDEAD;
        #1;
        chk("redir_restart_lo", fetch_restart, 0);
        tick();
        redirect = 1'b0; fetch_ready = 1'b0;
        #1;
        chk("redir_count", count, 0);
        chk("redir_pc", pc, 23'h000100);
        chk("redir_faddr", fetch_addr, 23'h000100);
        chk("redir_restart_hi", fetch_restart, 1);
        chk("redir_ready", instr_ready, 0);

        start_fetch();
        push(16'h4441, 0);
        push(16'h5552, 0);
        // simultaneous write and 16-bit consume at count 2
        fetch_ready = 1'b1; fetch_data = 16'h6660; consume = 1'b1;
        #1;
        chk("wc_stall", fetch_stall, 0);
        tick();
        fetch_ready = 1'b0; consume = 1'b0;
        #1;
        chk("wc_count", count, 2);
        chk("wc_pc", pc, 23'h000101);
        chk("wc_instr", instr, 32'h6660_5552);
        chk("wc_faddr", fetch_addr, 23'h000103);

        pop();
        chk("c1_count", count, 1);
        chk("c1_ready", instr_ready, 1);
        chk("c1_len", instr_len, 2'b01);
        chk("c1_lo", instr[15:0], 16'h6660);
        pop();
        chk("empty_count", count, 0);
        chk("empty_pc", pc, 23'h000103);
        chk("empty_ready", instr_ready, 0);

        // 32-bit instruction straddling slot 3 -> slot 0
        push(16'h0093, 0);
        chk("half_count", count, 1);
        chk("half_ready", instr_ready, 0);
        chk("half_len", instr_len, 2'b10);
        push(16'h00A0, 0);
        chk("wrap_instr", instr, 32'h00A0_0093);
        chk("wrap_ready", instr_ready, 1);
        chk("wrap_len", instr_len, 2'b10);
        pop();
        chk("wrap_count", count, 0);
        chk("wrap_pc", pc, 23'h000105);
        chk("wrap_faddr", fetch_addr, 23'h000105);

        // asynchronous reset mid-run with count 3
        push(16'h1234, 0);
        push(16'h5678, 0);
        push(16'h9ABC, 1);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_stall", fetch_stall, 1);
        rstn = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_restart", fetch_restart, 1);
        chk("arst_stall", fetch_stall, 0);
        chk("arst_pc", pc, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // fetch_stopped returns to idle; idle data is discarded
        start_fetch();
        chk("run2_restart", fetch_restart, 0);
        fetch_stopped = 1'b1;
        tick();
        fetch_stopped = 1'b0;
        #1;
        chk("stop_restart", fetch_restart, 1);
        fetch_ready = 1'b1; fetch_data = 16'h0001;
        tick();
        fetch_ready = 1'b0;
        #1;
        chk("idle_drop_count", count, 0);

        // pc wraps at the top of the address space
        redirect = 1'b1; redirect_addr = 23'h7FFFFF;
        tick();
        redirect = 1'b0;
        #1;
        chk("top_pc", pc, 23'h7FFFFF);
        start_fetch();
        push(16'h0001, 0);
        pop();
        chk("pcwrap_pc", pc, 0);
        chk("pcwrap_faddr", fetch_addr, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
